// File: rtl/demux_leds_temporizado.sv
// Timed 1-to-N LED demultiplexer: lights the selected LED for T_ON clocks,
// blanks all LEDs for T_OFF clocks, then pulses pronto for one clock.
module demux_leds_temporizado #(
    parameter int N     = 4,
    parameter int SEL_W = 2,
    parameter int T_ON  = 50,
    parameter int T_OFF = 25
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             iniciar,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]     leds,
    output logic             ocupado,
    output logic             pronto,
    output logic             erro
);

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] ACESO   = 2'd1;
    localparam logic [1:0] APAGADO = 2'd2;
    localparam logic [1:0] FIM     = 2'd3;

    localparam int TMAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int CW   = $clog2(TMAX + 1);

    localparam logic [CW-1:0]  ON_LAST  = CW'(T_ON - 1);
    localparam logic [CW-1:0]  OFF_LAST = CW'((T_OFF > 0) ? T_OFF - 1 : 0);
    localparam logic [SEL_W:0] N_L      = (SEL_W + 1)'(N);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N-1:0]     leds_q, leds_d;
    logic             ocupado_q, ocupado_d;
    logic             pronto_q, pronto_d;
    logic             erro_q, erro_d;
    logic             sel_ok;

    function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] s);
        decode = '0;
        for (int i = 0; i < N; i++) begin
            decode[i] = (s == SEL_W'(i));
        end
    endfunction

    assign sel_ok = ({1'b0, sel} < N_L);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        leds_d    = leds_q;
        ocupado_d = ocupado_q;
        pronto_d  = 1'b0;
        erro_d    = 1'b0;
        case (state_q)
            OCIOSO: begin
                if (iniciar) begin
                    if (sel_ok) begin
                        state_d   = ACESO;
                        cnt_d     = '0;
                        sel_d     = sel;
                        leds_d    = decode(sel);
                        ocupado_d = 1'b1;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            ACESO: begin
                // LED drops on the edge that ends the T_ON-th lit clock
                if (cnt_q == ON_LAST) begin
                    leds_d = '0;
                    cnt_d  = '0;
                    if (T_OFF == 0) begin
                        state_d  = FIM;
                        pronto_d = 1'b1;
                    end else begin
                        state_d = APAGADO;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            APAGADO: begin
                if (cnt_q == OFF_LAST) begin
                    state_d  = FIM;
                    cnt_d    = '0;
                    pronto_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIM: begin
                state_d   = OCIOSO;
                cnt_d     = '0;
                ocupado_d = 1'b0;
            end
            default: begin
                state_d   = OCIOSO;
                cnt_d     = '0;
                leds_d    = '0;
                ocupado_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= OCIOSO;
            cnt_q     <= '0;
            sel_q     <= '0;
            leds_q    <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            leds_q    <= leds_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
            erro_q    <= erro_d;
        end
    end

    assign leds    = leds_q;
    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;
    assign erro    = erro_q;

endmodule

// File: tb/tb_demux_leds_temporizado.sv
// Bench for demux_leds_temporizado: vector table through a scoreboard
// queue on an N=4 instance, plus an N=3 instance for the sel>=N error path.
module tb_demux_leds_temporizado;

    typedef struct {
        string      name;
        logic       rst;
        logic       ini;
        logic [1:0] sel;
        logic [6:0] exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [3:0] leds;
    logic       ocupado, pronto, erro;

    logic       iniciar3 = 1'b0;
    logic [1:0] sel3 = 2'd0;
    logic [2:0] leds3;
    logic       ocupado3, pronto3, erro3;

    vec_t       vecs[$];
    logic [6:0] exp_q[$];
    logic [5:0] exp3_q[$];
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clock = ~clock;

    demux_leds_temporizado #(
        .N(4), .SEL_W(2), .T_ON(4), .T_OFF(2)
    ) dut4 (
        .clock   (clock),
        .reset   (reset),
        .iniciar (iniciar),
        .sel     (sel),
        .leds    (leds),
        .ocupado (ocupado),
        .pronto  (pronto),
        .erro    (erro)
    );

    demux_leds_temporizado #(
        .N(3), .SEL_W(2), .T_ON(4), .T_OFF(2)
    ) dut3 (
        .clock   (clock),
        .reset   (reset),
        .iniciar (iniciar3),
        .sel     (sel3),
        .leds    (leds3),
        .ocupado (ocupado3),
        .pronto  (pronto3),
        .erro    (erro3)
    );

    function automatic void add(
        input string nm, input logic r, input logic i,
        input logic [1:0] s, input logic [3:0] l,
        input logic oc, input logic pr, input logic er);
        vec_t v;
        v.name = nm;
        v.rst  = r;
        v.ini  = i;
        v.sel  = s;
        v.exp  = {l, oc, pr, er};
        vecs.push_back(v);
    endfunction

    task automatic step4(input vec_t v);
        logic [6:0] got, want;
        reset   = v.rst;
        iniciar = v.ini;
        sel     = v.sel;
        exp_q.push_back(v.exp);
        @(posedge clock);
        #1;
        got  = {leds, ocupado, pronto, erro};
        want = exp_q.pop_front();
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got leds/oc/pr/er=%b want=%b", v.name, got, want);
        end
    endtask

    task automatic step3(input string nm, input logic i,
                         input logic [1:0] s, input logic [5:0] e);
        logic [5:0] got, want;
        iniciar3 = i;
        sel3     = s;
        exp3_q.push_back(e);
        @(posedge clock);
        #1;
        got  = {leds3, ocupado3, pronto3, erro3};
        want = exp3_q.pop_front();
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got leds/oc/pr/er=%b want=%b", nm, got, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        add("reset_1",       1, 0, 2'd0, 4'b0000, 0, 0, 0);
        add("reset_2",       1, 0, 2'd0, 4'b0000, 0, 0, 0);
        add("idle",          0, 0, 2'd0, 4'b0000, 0, 0, 0);
        add("start_sel2",    0, 1, 2'd2, 4'b0100, 1, 0, 0);
        add("aceso_2",       0, 0, 2'd2, 4'b0100, 1, 0, 0);
        add("aceso_ign_ini", 0, 1, 2'd1, 4'b0100, 1, 0, 0);
        add("aceso_4",       0, 0, 2'd1, 4'b0100, 1, 0, 0);
        add("apagado_1",     0, 0, 2'd0, 4'b0000, 1, 0, 0);
        add("apagado_2",     0, 0, 2'd0, 4'b0000, 1, 0, 0);
        add("fim_pronto",    0, 0, 2'd0, 4'b0000, 1, 1, 0);
        add("back_idle",     0, 0, 2'd0, 4'b0000, 0, 0, 0);
        add("start_sel0",    0, 1, 2'd0, 4'b0001, 1, 0, 0);
        add("aceso_2nd",     0, 0, 2'd0, 4'b0001, 1, 0, 0);
        add("mid_reset",     1, 0, 2'd0, 4'b0000, 0, 0, 0);
        add("post_reset_1",  0, 0, 2'd0, 4'b0000, 0, 0, 0);
        add("post_reset_2",  0, 0, 2'd0, 4'b0000, 0, 0, 0);
        add("start_sel3",    0, 1, 2'd3, 4'b1000, 1, 0, 0);
        add("sel3_on_2",     0, 0, 2'd3, 4'b1000, 1, 0, 0);
        add("sel3_on_3",     0, 0, 2'd3, 4'b1000, 1, 0, 0);
        add("sel3_on_4",     0, 0, 2'd3, 4'b1000, 1, 0, 0);
        add("sel3_off_1",    0, 0, 2'd3, 4'b0000, 1, 0, 0);
        add("sel3_off_2",    0, 1, 2'd3, 4'b0000, 1, 0, 0);
        add("sel3_fim",      0, 1, 2'd3, 4'b0000, 1, 1, 0);
        add("fim_no_accept", 0, 1, 2'd3, 4'b0000, 0, 0, 0);
        add("restart_sel3",  0, 1, 2'd3, 4'b1000, 1, 0, 0);
        add("re_on_2",       0, 0, 2'd0, 4'b1000, 1, 0, 0);
        add("re_on_3",       0, 0, 2'd0, 4'b1000, 1, 0, 0);
        add("re_on_4",       0, 0, 2'd0, 4'b1000, 1, 0, 0);
        add("re_off_1",      0, 0, 2'd0, 4'b0000, 1, 0, 0);
        add("re_off_2",      0, 0, 2'd0, 4'b0000, 1, 0, 0);
        add("re_fim",        0, 0, 2'd0, 4'b0000, 1, 1, 0);
        add("re_idle",       0, 0, 2'd0, 4'b0000, 0, 0, 0);

        #1;
        foreach (vecs[k]) step4(vecs[k]);

        step3("n3_erro_pulse", 1, 2'd3, {3'b000, 1'b0, 1'b0, 1'b1});
        step3("n3_erro_clear", 0, 2'd3, {3'b000, 1'b0, 1'b0, 1'b0});
        step3("n3_start_sel2", 1, 2'd2, {3'b100, 1'b1, 1'b0, 1'b0});
        step3("n3_aceso_2",    0, 2'd0, {3'b100, 1'b1, 1'b0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
